// File: rtl/ccff_frame_chain.sv
// ============================================================================
// Module   : ccff_frame_chain
// Brief    : NUM_CHAINS x DEPTH configuration chain with shadow register,
//            frame-length check, circular readback and test isolation.
//            Optional even-parity stage per chain: define CCFF_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ccff_frame_chain #(
  parameter int NUM_CHAINS = 4,
  parameter int DEPTH      = 32
) (
  input  logic                          prog_clk,
  input  logic                          prog_rst_n,
  input  logic                          Test_en,
  input  logic [NUM_CHAINS-1:0]         ccff_head,
  input  logic                          ccff_en,
  input  logic                          ccff_readback,
  input  logic                          ccff_commit,
  output logic [NUM_CHAINS-1:0]         ccff_tail,
  output logic [NUM_CHAINS*DEPTH-1:0]   config_out,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_err
);

`ifdef CCFF_PARITY_EN
  localparam int c_len = DEPTH + 1;
`else
  localparam int c_len = DEPTH;
`endif
  localparam int c_req   = c_len;
  localparam int c_cnt_w = $clog2(c_req + 2);
  localparam logic [c_cnt_w-1:0] c_req_cnt = c_cnt_w'(c_req);
  localparam logic [c_cnt_w-1:0] c_sat_cnt = c_cnt_w'(c_req + 1);
  localparam logic [c_cnt_w-1:0] c_one_cnt = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [c_cnt_w-1:0]                count_q, count_d;
  logic [NUM_CHAINS-1:0][c_len-1:0]  chain_q, chain_d, chain_shifted;
  logic [NUM_CHAINS-1:0][DEPTH-1:0]  shadow_q, shadow_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;
  logic [NUM_CHAINS-1:0]             par_ok;
  logic                              shift_req;
  logic                              frame_ok;

  generate
    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
      assign chain_shifted[c] = {chain_q[c][c_len-2:0],
                                 ccff_readback ? chain_q[c][c_len-1] : ccff_head[c]};
      assign ccff_tail[c]     = chain_q[c][c_len-1];
`ifdef CCFF_PARITY_EN
      assign par_ok[c]        = ~(^chain_q[c]);
`else
      assign par_ok[c]        = 1'b1;
`endif
    end
  endgenerate

  // A commit in the same cycle as an enable takes priority and blocks the shift.
  assign shift_req = ccff_en & ~ccff_commit;
  assign frame_ok  = (count_q == c_req_cnt) & (&par_ok);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    chain_d  = chain_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if (shift_req) begin
      chain_d = chain_shifted;
    end

    case (state_q)
      ST_IDLE: begin
        if (shift_req) begin
          state_d = ST_SHIFT;
          count_d = c_one_cnt;
        end
      end
      ST_SHIFT: begin
        if (ccff_commit) begin
          count_d = '0;
          if (frame_ok) begin
            for (int c = 0; c < NUM_CHAINS; c++) begin
              shadow_d[c] = chain_q[c][DEPTH-1:0];
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end else if (ccff_en) begin
          count_d = (count_q == c_sat_cnt) ? count_q : count_q + c_one_cnt;
        end
      end
      ST_ERROR: begin
        if (shift_req) begin
          state_d = ST_SHIFT;
          count_d = c_one_cnt;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      chain_q  <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      chain_q  <= chain_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign config_out = Test_en ? '0 : shadow_q;
  assign cfg_busy   = busy_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;

endmodule

`default_nettype wire
